// File: rtl/sniffer_sched_pkg.sv
// Shared types and default parameters for the sniffer scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sniffer_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DRAIN  = 2'd3
    } sched_state_t;

    localparam int         DEF_NUM_REQ      = 4;
    localparam logic [7:0] DEF_FLUSH_CHAR   = 8'h20;
    localparam int         DEF_DRAIN_CYCLES = 2;

endpackage

// File: rtl/sniffer_scheduler_rr_arbiter.sv
// Round-robin pick: lowest requester index at or after rr_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to take the grant.
//
// Ports:
//   req       - per-requester request vector
//   rr_ptr    - index where the search starts
//   grant_idx - chosen requester (valid only when grant_vld)
//   grant_vld - at least one request is present
module rr_arbiter #(
    parameter  int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] rr_ptr,
    output logic [W-1:0] grant_idx,
    output logic         grant_vld
);

    function automatic logic [W-1:0] wrap_idx(input logic [W-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N) s = s - N;
        return W'(s);
    endfunction

    // Scan offsets from farthest to nearest so the last hit wins, which is
    // the requester closest to rr_ptr.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[wrap_idx(rr_ptr, i)]) begin
                grant_idx = wrap_idx(rr_ptr, i);
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sniffer_scheduler.sv
// Time-shares one byte sniffer between NUM_REQ byte-stream requesters, round-robin per frame.
// Latency: accepted byte appears on snf_data 1 cycle later; sniffer output tagged 1 cycle later.
// Backpressure: req_ready only for the frame owner in STREAM; out_* has none.
//
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   req_valid/data/last     - per-requester byte stream in (byte k at [8k+7:8k])
//   req_ready               - per-requester accept
//   snf_enable, snf_data    - drive the sniffer
//   snf_write, snf_data_out - sniffer output strobe and character
//   out_valid/data/src      - sniffer character tagged with the owning requester
//   busy                    - scheduler not idle
module sniffer_scheduler
    import sniffer_sched_pkg::*;
#(
    parameter  int         NUM_REQ      = DEF_NUM_REQ,
    parameter  logic [7:0] FLUSH_CHAR   = DEF_FLUSH_CHAR,
    parameter  int         DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    localparam int         IDX_W        = $clog2(NUM_REQ),
    localparam int         CNT_W        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 snf_enable,
    output logic [7:0]           snf_data,
    input  logic                 snf_write,
    input  logic [7:0]           snf_data_out,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    output logic [IDX_W-1:0]     out_src,
    output logic                 busy
);

    sched_state_t     state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0] drain_cnt;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_vld;
    logic             xfer;
    logic [7:0]       owner_byte;
    logic [IDX_W-1:0] next_ptr;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign busy       = (state != ST_IDLE);
    assign xfer       = (state == ST_STREAM) && req_valid[owner];
    assign owner_byte = req_data[{owner, 3'b000} +: 8];
    assign next_ptr   = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    // Ready is decoded from state so reset clears it without waiting for a clock.
    always_comb begin
        req_ready = '0;
        if (state == ST_STREAM) req_ready[owner] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            owner      <= '0;
            rr_ptr     <= '0;
            drain_cnt  <= '0;
            snf_enable <= 1'b0;
            snf_data   <= 8'h00;
        end else begin
            snf_enable <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        owner <= grant_idx;
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (xfer) begin
                        snf_enable <= 1'b1;
                        snf_data   <= owner_byte;
                        if (req_last[owner]) state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // The last frame byte is on snf_data during this cycle,
                    // so the separator is registered to follow it.
                    snf_enable <= 1'b1;
                    snf_data   <= FLUSH_CHAR;
                    drain_cnt  <= '0;
                    state      <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drain_cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
                        rr_ptr <= next_ptr;
                        state  <= ST_IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Owner is kept through IDLE, so late sniffer output is tagged with the
    // requester whose frame produced it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_src   <= '0;
        end else begin
            out_valid <= snf_write;
            if (snf_write) begin
                out_data <= snf_data_out;
                out_src  <= owner;
            end
        end
    end

endmodule
